// File: rtl/operand_issue_pkg.sv
// rtl/operand_issue_pkg.sv - shared widths, instruction record and FSM states for operand issue
package operand_issue_pkg;

    localparam int DEF_DATA_WIDTH = 4;
    localparam int DEF_ADDR_WIDTH = 2;

    typedef struct packed {
        logic [DEF_ADDR_WIDTH-1:0] dst;
        logic [DEF_ADDR_WIDTH-1:0] src0;
        logic [DEF_ADDR_WIDTH-1:0] src1;
        logic                      wen;
    } instr_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HELD  = 1'b1
    } issue_state_t;

endpackage

// File: rtl/operand_scoreboard.sv
// rtl/operand_scoreboard.sv - pending-write bits with writeback clears and hazard lookup
module operand_scoreboard
    import operand_issue_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                     real_clk,
    input  logic                     real_rst,
    input  logic                     wb0_valid,
    input  logic [ADDR_WIDTH-1:0]    wb0_addr,
    input  logic                     wb1_valid,
    input  logic [ADDR_WIDTH-1:0]    wb1_addr,
    input  logic                     set_valid,
    input  logic [ADDR_WIDTH-1:0]    set_addr,
    input  logic [ADDR_WIDTH-1:0]    look_src0,
    input  logic [ADDR_WIDTH-1:0]    look_src1,
    input  logic [ADDR_WIDTH-1:0]    look_dst,
    input  logic                     look_wen,
    output logic                     hazard,
    output logic [2**ADDR_WIDTH-1:0] pending
);

    localparam int NREGS = 2**ADDR_WIDTH;

    logic [NREGS-1:0] clr_mask;
    logic [NREGS-1:0] set_mask;
    logic [NREGS-1:0] pend_eff;

    // Writebacks landing this cycle are already visible through the
    // register-file bypass, so they are removed before the hazard lookup.
    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (wb0_valid) clr_mask[wb0_addr] = 1'b1;
        if (wb1_valid) clr_mask[wb1_addr] = 1'b1;
        if (set_valid) set_mask[set_addr] = 1'b1;
        pend_eff = pending & ~clr_mask;
        hazard   = pend_eff[look_src0] || pend_eff[look_src1] ||
                   (look_wen && pend_eff[look_dst]);
    end

    // Set is ORed after the clear so a new producer outranks a stale writeback.
    always_ff @(posedge real_clk) begin
        if (!real_rst) begin
            pending <= '0;
        end else begin
            pending <= pend_eff | set_mask;
        end
    end

endmodule

// File: rtl/operand_issue.sv
// rtl/operand_issue.sv - single-entry operand issue stage with scoreboard stall and output register
module operand_issue
    import operand_issue_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  real_clk,
    input  logic                  real_rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_dst,
    input  logic [ADDR_WIDTH-1:0] in_src0,
    input  logic [ADDR_WIDTH-1:0] in_src1,
    input  logic                  in_wen,
    output logic [ADDR_WIDTH-1:0] read_addr0,
    output logic [ADDR_WIDTH-1:0] read_addr1,
    input  logic [DATA_WIDTH-1:0] read_data0,
    input  logic [DATA_WIDTH-1:0] read_data1,
    input  logic                  wb0_valid,
    input  logic [ADDR_WIDTH-1:0] wb0_addr,
    input  logic                  wb1_valid,
    input  logic [ADDR_WIDTH-1:0] wb1_addr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_op0,
    output logic [DATA_WIDTH-1:0] out_op1,
    output logic [ADDR_WIDTH-1:0] out_dst,
    output logic                  out_wen
);

    issue_state_t state;
    instr_t       hr;
    logic         held;
    logic         hazard;
    logic         issue;
    logic         accept;
    logic [2**ADDR_WIDTH-1:0] pending;

    assign held     = (state == ST_HELD);
    assign issue    = held && !hazard && (!out_valid || out_ready);
    assign in_ready = real_rst && (!held || issue);
    assign accept   = in_valid && in_ready;

    assign read_addr0 = held ? hr.src0 : '0;
    assign read_addr1 = held ? hr.src1 : '0;

    operand_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scoreboard (
        .real_clk  (real_clk),
        .real_rst  (real_rst),
        .wb0_valid (wb0_valid),
        .wb0_addr  (wb0_addr),
        .wb1_valid (wb1_valid),
        .wb1_addr  (wb1_addr),
        .set_valid (issue && hr.wen),
        .set_addr  (hr.dst),
        .look_src0 (hr.src0),
        .look_src1 (hr.src1),
        .look_dst  (hr.dst),
        .look_wen  (hr.wen),
        .hazard    (hazard),
        .pending   (pending)
    );

    // Holding register: a reload in the issue cycle keeps the stage at one per cycle.
    always_ff @(posedge real_clk) begin
        if (!real_rst) begin
            state <= ST_EMPTY;
            hr    <= '0;
        end else if (accept) begin
            state   <= ST_HELD;
            hr.dst  <= in_dst;
            hr.src0 <= in_src0;
            hr.src1 <= in_src1;
            hr.wen  <= in_wen;
        end else if (issue) begin
            state <= ST_EMPTY;
        end
    end

    always_ff @(posedge real_clk) begin
        if (!real_rst) begin
            out_valid <= 1'b0;
            out_op0   <= '0;
            out_op1   <= '0;
            out_dst   <= '0;
            out_wen   <= 1'b0;
        end else if (issue) begin
            out_valid <= 1'b1;
            out_op0   <= read_data0;
            out_op1   <= read_data1;
            out_dst   <= hr.dst;
            out_wen   <= hr.wen;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_issue.sv
// tb/tb_operand_issue.sv - directed self-checking bench for operand_issue
module tb_operand_issue;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, in_wen;
    logic [1:0] in_dst, in_src0, in_src1;
    logic [1:0] read_addr0, read_addr1;
    logic [3:0] read_data0, read_data1;
    logic       wb0_valid, wb1_valid;
    logic [1:0] wb0_addr, wb1_addr;
    logic [3:0] wb0_data, wb1_data;
    logic       out_valid, out_ready, out_wen;
    logic [3:0] out_op0, out_op1;
    logic [1:0] out_dst;
    logic       rf_load;
    logic [3:0] rf [4];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    operand_issue dut (
        .real_clk   (clk),
        .real_rst   (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_dst     (in_dst),
        .in_src0    (in_src0),
        .in_src1    (in_src1),
        .in_wen     (in_wen),
        .read_addr0 (read_addr0),
        .read_addr1 (read_addr1),
        .read_data0 (read_data0),
        .read_data1 (read_data1),
        .wb0_valid  (wb0_valid),
        .wb0_addr   (wb0_addr),
        .wb1_valid  (wb1_valid),
        .wb1_addr   (wb1_addr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_op0    (out_op0),
        .out_op1    (out_op1),
        .out_dst    (out_dst),
        .out_wen    (out_wen)
    );

    // Register file model with write-through bypass on its two write ports.
    always @(posedge clk) begin
        if (rf_load) begin
            rf[0] <= 4'd4;
            rf[1] <= 4'd1;
            rf[2] <= 4'd5;
            rf[3] <= 4'd9;
        end else begin
            if (wb0_valid) rf[wb0_addr] <= wb0_data;
            if (wb1_valid) rf[wb1_addr] <= wb1_data;
        end
    end

    always_comb begin
        read_data0 = rf[read_addr0];
        read_data1 = rf[read_addr1];
        if (wb0_valid && wb0_addr == read_addr0) read_data0 = wb0_data;
        if (wb1_valid && wb1_addr == read_addr0) read_data0 = wb1_data;
        if (wb0_valid && wb0_addr == read_addr1) read_data1 = wb0_data;
        if (wb1_valid && wb1_addr == read_addr1) read_data1 = wb1_data;
    end

    task automatic set_in(input logic v, input logic [1:0] d, input logic [1:0] s0,
                          input logic [1:0] s1, input logic w);
        in_valid = v;
        in_dst   = d;
        in_src0  = s0;
        in_src1  = s1;
        in_wen   = w;
    endtask

    task automatic set_wb(input logic v0, input logic [1:0] a0, input logic [3:0] d0,
                          input logic v1, input logic [1:0] a1, input logic [3:0] d1);
        wb0_valid = v0; wb0_addr = a0; wb0_data = d0;
        wb1_valid = v1; wb1_addr = a1; wb1_data = d1;
    endtask

    task automatic test_reset;
        rst = 1'b0; rf_load = 1'b1; out_ready = 1'b1;
        set_in(1'b1, 2'd0, 2'd0, 2'd0, 1'b0);
        set_wb(1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 4'd0);
        repeat (2) @(negedge clk);
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        total++; if ({out_op0, out_op1, out_dst, out_wen} !== 11'd0) begin bad++; $display("FAIL reset_out_fields got=%0h exp=0", {out_op0, out_op1, out_dst, out_wen}); end
        total++; if (dut.u_scoreboard.pending !== 4'b0000) begin bad++; $display("FAIL reset_pending got=%b exp=0000", dut.u_scoreboard.pending); end
        @(negedge clk);
        rst = 1'b1; rf_load = 1'b0;
        set_in(1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
    endtask

    task automatic test_basic_issue;
        @(negedge clk);
        set_in(1'b1, 2'd1, 2'd2, 2'd3, 1'b1);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_in_ready got=%0b exp=1", in_ready); end
        @(negedge clk);
        set_in(1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_t1_valid got=%0b exp=0", out_valid); end
        total++; if (read_addr0 !== 2'd2 || read_addr1 !== 2'd3) begin bad++; $display("FAIL basic_read_addr got=%0d,%0d exp=2,3", read_addr0, read_addr1); end
        @(negedge clk);
        #1;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_t2_valid got=%0b exp=1", out_valid); end
        total++; if (out_op0 !== 4'd5 || out_op1 !== 4'd9) begin bad++; $display("FAIL basic_ops got=%0d,%0d exp=5,9", out_op0, out_op1); end
        total++; if (out_dst !== 2'd1 || out_wen !== 1'b1) begin bad++; $display("FAIL basic_dst got=%0d/%0b exp=1/1", out_dst, out_wen); end
        total++; if (dut.u_scoreboard.pending !== 4'b0010) begin bad++; $display("FAIL basic_pending got=%b exp=0010", dut.u_scoreboard.pending); end
    endtask

    task automatic test_stall_wb;
        set_in(1'b1, 2'd0, 2'd1, 2'd0, 1'b0);
        @(negedge clk);
        set_in(1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
        #1;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL stall_a got=%0b/%0b exp=0/0", out_valid, in_ready); end
        @(negedge clk);
        #1;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL stall_b got=%0b/%0b exp=0/0", out_valid, in_ready); end
        set_wb(1'b1, 2'd1, 4'd7, 1'b0, 2'd0, 4'd0);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_wb_issue got=%0b exp=1", in_ready); end
        @(negedge clk);
        set_wb(1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 4'd0);
        #1;
        total++; if (out_valid !== 1'b1 || out_op0 !== 4'd7 || out_op1 !== 4'd4) begin bad++; $display("FAIL stall_ops got=%0b/%0d/%0d exp=1/7/4", out_valid, out_op0, out_op1); end
        total++; if (dut.u_scoreboard.pending !== 4'b0000) begin bad++; $display("FAIL stall_pending got=%b exp=0000", dut.u_scoreboard.pending); end
    endtask

    task automatic test_set_wins;
        set_in(1'b1, 2'd2, 2'd0, 2'd3, 1'b1);
        @(negedge clk);
        set_in(1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
        set_wb(1'b0, 2'd0, 4'd0, 1'b1, 2'd2, 4'd6);
        @(negedge clk);
        set_wb(1'b1, 2'd2, 4'd8, 1'b1, 2'd2, 4'd8);
        #1;
        total++; if (dut.u_scoreboard.pending !== 4'b0100) begin bad++; $display("FAIL setwins_pending got=%b exp=0100", dut.u_scoreboard.pending); end
        total++; if (out_op0 !== 4'd4 || out_op1 !== 4'd9 || out_dst !== 2'd2) begin bad++; $display("FAIL setwins_out got=%0d/%0d/%0d exp=4/9/2", out_op0, out_op1, out_dst); end
        @(negedge clk);
        set_wb(1'b1, 2'd3, 4'd9, 1'b0, 2'd0, 4'd0);
        @(negedge clk);
        set_wb(1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 4'd0);
        #1;
        total++; if (dut.u_scoreboard.pending !== 4'b0000) begin bad++; $display("FAIL dualwb_pending got=%b exp=0000", dut.u_scoreboard.pending); end
    endtask

    task automatic test_self_dep;
        set_in(1'b1, 2'd1, 2'd1, 2'd1, 1'b1);
        @(negedge clk);
        set_in(1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
        @(negedge clk);
        #1;
        total++; if (out_valid !== 1'b1 || out_op0 !== 4'd7 || out_op1 !== 4'd7) begin bad++; $display("FAIL selfdep_out got=%0b/%0d/%0d exp=1/7/7", out_valid, out_op0, out_op1); end
        total++; if (dut.u_scoreboard.pending !== 4'b0010) begin bad++; $display("FAIL selfdep_pending got=%b exp=0010", dut.u_scoreboard.pending); end
        set_wb(1'b1, 2'd1, 4'd3, 1'b0, 2'd0, 4'd0);
        @(negedge clk);
        set_wb(1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 4'd0);
        #1;
        total++; if (dut.u_scoreboard.pending !== 4'b0000 || out_valid !== 1'b0) begin bad++; $display("FAIL selfdep_clear got=%b/%0b exp=0000/0", dut.u_scoreboard.pending, out_valid); end
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b0;
        set_in(1'b1, 2'd1, 2'd0, 2'd0, 1'b1);
        @(negedge clk);
        set_in(1'b1, 2'd2, 2'd0, 2'd0, 1'b1);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_reload_ready got=%0b exp=1", in_ready); end
        @(negedge clk);
        set_in(1'b1, 2'd3, 2'd0, 2'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            total++; if (out_valid !== 1'b1 || out_dst !== 2'd1 || out_op0 !== 4'd4) begin bad++; $display("FAIL b2b_hold%0d got=%0b/%0d/%0d exp=1/1/4", i, out_valid, out_dst, out_op0); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_hold_ready%0d got=%0b exp=0", i, in_ready); end
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_resume_ready got=%0b exp=1", in_ready); end
        @(negedge clk);
        set_in(1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
        #1;
        total++; if (out_valid !== 1'b1 || out_dst !== 2'd2) begin bad++; $display("FAIL b2b_second got=%0b/%0d exp=1/2", out_valid, out_dst); end
        @(negedge clk);
        #1;
        total++; if (out_valid !== 1'b1 || out_dst !== 2'd3) begin bad++; $display("FAIL b2b_third got=%0b/%0d exp=1/3", out_valid, out_dst); end
        set_wb(1'b1, 2'd1, 4'd1, 1'b1, 2'd2, 4'd2);
        @(negedge clk);
        set_wb(1'b1, 2'd3, 4'd3, 1'b0, 2'd0, 4'd0);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%0b exp=0", out_valid); end
        @(negedge clk);
        set_wb(1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 4'd0);
        #1;
        total++; if (dut.u_scoreboard.pending !== 4'b0000) begin bad++; $display("FAIL b2b_pending got=%b exp=0000", dut.u_scoreboard.pending); end
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        set_in(1'b1, 2'd1, 2'd0, 2'd0, 1'b1);
        @(negedge clk);
        set_in(1'b1, 2'd2, 2'd0, 2'd0, 1'b1);
        @(negedge clk);
        set_in(1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
        #1;
        total++; if (out_valid !== 1'b1 || dut.u_scoreboard.pending !== 4'b0010) begin bad++; $display("FAIL rstmid_pre got=%0b/%b exp=1/0010", out_valid, dut.u_scoreboard.pending); end
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rstmid_ready_low got=%0b exp=0", in_ready); end
        @(negedge clk);
        set_in(1'b1, 2'd3, 2'd0, 2'd0, 1'b1);
        #1;
        total++; if (out_valid !== 1'b0 || dut.u_scoreboard.pending !== 4'b0000) begin bad++; $display("FAIL rstmid_clear got=%0b/%b exp=0/0000", out_valid, dut.u_scoreboard.pending); end
        total++; if (out_dst !== 2'd0 || out_op0 !== 4'd0 || in_ready !== 1'b0) begin bad++; $display("FAIL rstmid_fields got=%0d/%0d/%0b exp=0/0/0", out_dst, out_op0, in_ready); end
        @(negedge clk);
        rst = 1'b1; out_ready = 1'b1;
        set_in(1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_release_ready got=%0b exp=1", in_ready); end
        @(negedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_no_issue got=%0b exp=0", out_valid); end
    endtask

    initial begin
        test_reset;
        test_basic_issue;
        test_stall_wb;
        test_set_wins;
        test_self_dep;
        test_back_to_back;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/operand_issue.md
OPERAND_ISSUE -- requirements
Module: operand_issue

Interface
REQ-001 Parameter: DATA_WIDTH, 4, register data width; matches register-file entry width.
REQ-002 Parameter: ADDR_WIDTH, 2, register address width; NREGS = 2**ADDR_WIDTH = 4.
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 RESETN  in  1  reset, synchronous, active-low.
REQ-005 in_valid / in_ready  in / out  1 / 1  upstream instruction handshake.
REQ-006 in_dst, in_src0, in_src1  in  ADDR_WIDTH each  destination and source register addresses.
REQ-007 in_wen  in  1  instruction writes in_dst.
REQ-008 read_addr0, read_addr1  out  ADDR_WIDTH each  drive the register-file read ports.
REQ-009 read_data0, read_data1  in  DATA_WIDTH each  register-file read results; combinational, same cycle, write-bypassed.
REQ-010 wb0_valid, wb0_addr, wb1_valid, wb1_addr  in  1/ADDR_WIDTH each  writeback notifications, concurrent with the register-file write ports.
REQ-011 out_valid / out_ready  out / in  1 / 1  downstream operand handshake.
REQ-012 out_op0, out_op1  out  DATA_WIDTH each  operands; out_dst  out  ADDR_WIDTH; out_wen  out  1.

Function
REQ-013 Holding register (HR) plus FSM with two states: EMPTY, HELD.
REQ-014 in_ready = RESETN && (state==EMPTY || issue); in_valid&&in_ready loads HR and enters HELD.
REQ-015 read_addr0/1 = HR src0/src1 in HELD; 0 in EMPTY.
REQ-016 Scoreboard: NREGS pending bits; hazard = pending[src0] || pending[src1] || (HR.wen && pending[dst]).
REQ-017 Pending bits used for hazard = registered bits with this cycle's wb0/wb1 clears applied, so same-cycle writeback resolves the stall; read data is correct via register-file bypass.
REQ-018 issue = HELD && !hazard && (!out_valid || out_ready).
REQ-019 On issue: out_op0/1 <= read_data0/1, out_dst/out_wen <= HR fields, out_valid <= 1, pending[dst] <= 1 if wen.
REQ-020 Simultaneous set and wb clear of the same bit: set wins.
REQ-021 wb0 and wb1 to the same address: bit cleared once, no error.
REQ-022 wb to a non-pending register: no effect.
REQ-023 Issue and accept in the same cycle: HR reloads, state stays HELD; back-to-back throughput 1/cycle with no hazard.
REQ-024 Output held stable while out_valid && !out_ready; out_valid cleared on out_ready when no issue.
REQ-025 Latency: accept in cycle t -> out_valid in cycle t+2 minimum.
REQ-026 Self-dependency (src == dst of HR): only prior pending matters; own set never stalls itself.

Reset
REQ-027 RESETN low at an edge: state EMPTY, pending all 0, out_valid 0, out_op0/1/out_dst/out_wen 0.
REQ-028 in_ready is 0 while RESETN is low.
REQ-029 Reset mid-operation discards HR and output contents; no partial issue.

Structure
REQ-030 Shared package holds DATA_WIDTH/ADDR_WIDTH defaults, the instruction struct {dst, src0, src1, wen}, and the FSM state enum.
REQ-031 One sub-module: operand_scoreboard (pending bits, set/clear, hazard lookup); everything else in operand_issue.

Verification
REQ-032 After reset, in {dst=1, src0=2, src1=3, wen=1}, reg2=5, reg3=9 -> out_valid at t+2 with op0=5, op1=9, dst=1; pending[1]=1.
REQ-033 Next instruction src0=1 -> stall; wb0_valid addr 1 with write_data=7 in cycle k -> issue in cycle k, op0=7, pending[1]=0.
REQ-034 out_ready=0 for 3 cycles with stream of 3 independent instructions -> output stable; in_ready=0 while HELD; no loss; then 1/cycle.
REQ-035 Issue setting pending[2] while wb1 clears addr 2 in the same cycle -> pending[2]=1 afterward.
REQ-036 RESETN low during HELD with out_valid=1 -> next cycle out_valid=0, pending=0, in_ready=0 until RESETN high.
